move_sequencer: RTL and testbench

- Controller in front of the 2048 board datapath.
- Turns raw L/R/U/D button levels into one move command at a time, handshaken to the board engine.
- After a move that changes the board, places the new tile (value 1) in a free cell starting from the random index, then updates win and game-over status.
- Owns new-game initialisation: clear the board, then spawn two tiles.

---
 rtl/move_sequencer_pkg.sv | 52 +++++
 rtl/move_sequencer_if.sv | 37 +++
 rtl/move_sequencer_btn_conditioner.sv | 77 +++++++
 rtl/move_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_move_sequencer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/move_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg: types, sizes and helpers shared by the 2048 move sequencer.
//   dir_t       : move direction encoding seen by the board engine.
//   seq_state_t : sequencer FSM states.
//   CELLS/CELL_W: board geometry (16 cells of 16 bits, cell i = row*4+col).
//   cell_at()   : extracts one cell value from the flat board vector.
//   pick_dir()  : fixed-priority U > D > L > R arbitration of button presses.
// -----------------------------------------------------------------------------
package game_pkg;

    localparam int CELLS            = 16;
    localparam int CELL_W           = 16;
    localparam int BOARD_W          = CELLS * CELL_W;
    localparam int WIN_LOG2_DEFAULT = 11;

    typedef enum logic [1:0] {
        DIR_U = 2'd0,
        DIR_D = 2'd1,
        DIR_L = 2'd2,
        DIR_R = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_INIT_CLR = 3'd0,
        ST_READY    = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_MV  = 3'd3,
        ST_FIND     = 3'd4,
        ST_SPAWN    = 3'd5,
        ST_CHECK    = 3'd6
    } seq_state_t;

    // Value (log2 of tile, 0 = empty) of cell idx.
    function automatic logic [CELL_W-1:0] cell_at(input logic [BOARD_W-1:0] board,
                                                  input logic [3:0]         idx);
        cell_at = board[int'(idx) * CELL_W +: CELL_W];
    endfunction

    // press = {u, d, l, r}; caller guarantees at least one bit is set.
    function automatic dir_t pick_dir(input logic [3:0] press);
        if (press[3]) begin
            pick_dir = DIR_U;
        end else if (press[2]) begin
            pick_dir = DIR_D;
        end else if (press[1]) begin
            pick_dir = DIR_L;
        end else begin
            pick_dir = DIR_R;
        end
    endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// -----------------------------------------------------------------------------
// move_sequencer_if: bus between the move sequencer and the 2048 board engine.
//   board_in   : engine -> sequencer, current board (16 x 16-bit cells).
//   mv_valid   : sequencer -> engine, move request.
//   mv_dir     : sequencer -> engine, move direction (0=U,1=D,2=L,3=R).
//   mv_ready   : engine -> sequencer, move accepted.
//   mv_done    : engine -> sequencer, 1-cycle move-complete pulse.
//   mv_changed : engine -> sequencer, board changed (qualified by mv_done).
//   clr        : sequencer -> engine, 1-cycle board clear.
//   spawn_we   : sequencer -> engine, 1-cycle write of tile value 1.
//   spawn_idx  : sequencer -> engine, cell written by spawn_we.
// master = sequencer side, slave = board engine side.
// -----------------------------------------------------------------------------
interface move_sequencer_if;
    import game_pkg::*;

    logic [BOARD_W-1:0] board_in;
    logic               mv_valid;
    logic [1:0]         mv_dir;
    logic               mv_ready;
    logic               mv_done;
    logic               mv_changed;
    logic               clr;
    logic               spawn_we;
    logic [3:0]         spawn_idx;

    modport master (
        input  board_in, mv_ready, mv_done, mv_changed,
        output mv_valid, mv_dir, clr, spawn_we, spawn_idx
    );

    modport slave (
        output board_in, mv_ready, mv_done, mv_changed,
        input  mv_valid, mv_dir, clr, spawn_we, spawn_idx
    );

endinterface

// File: rtl/move_sequencer_btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner: one raw button level -> single-cycle press pulse.
//   SYNC_STAGES-flop synchroniser, optional debounce, rising-edge detect.
// Optional macro BTN_DEBOUNCE_EN: the synchronised level must hold a new value
// for DEBOUNCE_CYCLES consecutive cycles before the edge detector sees it.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset.
//   btn_raw    : asynchronous button level.
//   press      : 1-cycle pulse on a (debounced) rising edge.
// -----------------------------------------------------------------------------
module btn_conditioner
    import game_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef BTN_DEBOUNCE_EN
    ,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   level_s;
    logic                   prev_r;

    // Synchroniser chain for the asynchronous button level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r[0] <= btn_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

`ifdef BTN_DEBOUNCE_EN
    logic        stable_r;
    logic [19:0] db_cnt_r;

    // Debounce: any return to the accepted level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_r <= 1'b0;
            db_cnt_r <= 20'd0;
        end else if (sync_r[SYNC_STAGES-1] == stable_r) begin
            db_cnt_r <= 20'd0;
        end else if (db_cnt_r >= DEBOUNCE_CYCLES - 20'd1) begin
            stable_r <= sync_r[SYNC_STAGES-1];
            db_cnt_r <= 20'd0;
        end else begin
            db_cnt_r <= db_cnt_r + 20'd1;
        end
    end

    assign level_s = stable_r;
`else
    assign level_s = sync_r[SYNC_STAGES-1];
`endif

    // Previous level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= level_s;
        end
    end

    assign press = level_s & ~prev_r;

endmodule

// File: rtl/move_sequencer.sv
// -----------------------------------------------------------------------------
// move_sequencer: controller in front of the 2048 board datapath.
// Turns button presses into one handshaken move at a time, spawns a value-1
// tile after every board-changing move, tracks win / game-over and owns
// new-game initialisation (clear, then two spawns).
// Optional macro BTN_DEBOUNCE_EN enables per-button debounce counters.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset.
//   btn_l/r/u/d          : raw button levels.
//   new_game             : 1-cycle pulse, restarts the game.
//   rnd                  : free-running random cell index.
//   bus                  : master side of move_sequencer_if (board engine).
//   busy                 : FSM is not in READY.
//   win, game_over       : sticky status, cleared by new_game.
//   move_count           : moves that changed the board (wraps).
// -----------------------------------------------------------------------------
module move_sequencer
    import game_pkg::*;
#(
    parameter int WIN_LOG2    = WIN_LOG2_DEFAULT,
    parameter int SYNC_STAGES = 2
`ifdef BTN_DEBOUNCE_EN
    ,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  btn_l,
    input  logic                  btn_r,
    input  logic                  btn_u,
    input  logic                  btn_d,
    input  logic                  new_game,
    input  logic [3:0]            rnd,
    move_sequencer_if.master      bus,
    output logic                  busy,
    output logic                  win,
    output logic                  game_over,
    output logic [15:0]           move_count
);

    // Button order {u, d, l, r} matches pick_dir().
    logic [3:0] btn_raw_s;
    logic [3:0] press_s;

    assign btn_raw_s = {btn_u, btn_d, btn_l, btn_r};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        btn_conditioner #(
            .SYNC_STAGES(SYNC_STAGES)
`ifdef BTN_DEBOUNCE_EN
            ,
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
        ) u_btn (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_raw(btn_raw_s[g]),
            .press  (press_s[g])
        );
    end

    seq_state_t  state_r,      state_nx;
    dir_t        mv_dir_r,     mv_dir_nx;
    logic        mv_valid_r,   mv_valid_nx;
    logic        clr_r,        clr_nx;
    logic        spawn_we_r,   spawn_we_nx;
    logic [3:0]  spawn_idx_r,  spawn_idx_nx;
    logic        busy_r,       busy_nx;
    logic        win_r,        win_nx;
    logic        game_over_r,  game_over_nx;
    logic [15:0] move_count_r, move_count_nx;
    logic [3:0]  ptr_r,        ptr_nx;
    logic [3:0]  scan_cnt_r,   scan_cnt_nx;
    logic [1:0]  spawn_cnt_r,  spawn_cnt_nx;
    logic        ng_pend_r,    ng_pend_nx;
    logic        abort_s;

    logic        board_full_s;
    logic        any_win_s;
    logic        pair_eq_s;

    // Board status: full, contains a winning tile, has a mergeable neighbour pair.
    always_comb begin
        board_full_s = 1'b1;
        any_win_s    = 1'b0;
        pair_eq_s    = 1'b0;
        for (int i = 0; i < CELLS; i++) begin
            board_full_s = board_full_s & (cell_at(bus.board_in, 4'(i)) != 16'd0);
            any_win_s    = any_win_s | (cell_at(bus.board_in, 4'(i)) >= 16'(WIN_LOG2));
            // Right neighbour exists unless in column 3; lower neighbour unless in row 3.
            pair_eq_s    = pair_eq_s
                         | (((i % 4) != 3) &&
                            (cell_at(bus.board_in, 4'(i)) == cell_at(bus.board_in, 4'(i + 1))))
                         | ((i < 12) &&
                            (cell_at(bus.board_in, 4'(i)) == cell_at(bus.board_in, 4'(i + 4))));
        end
    end

    // Next-state and next-output logic of the sequencer FSM.
    always_comb begin
        state_nx      = state_r;
        mv_dir_nx     = mv_dir_r;
        clr_nx        = 1'b0;
        spawn_idx_nx  = spawn_idx_r;
        win_nx        = win_r;
        game_over_nx  = game_over_r;
        move_count_nx = move_count_r;
        ptr_nx        = ptr_r;
        scan_cnt_nx   = scan_cnt_r;
        spawn_cnt_nx  = spawn_cnt_r;
        ng_pend_nx    = 1'b0;
        abort_s       = new_game;

        case (state_r)
            // Two cycles: first raises clr, second (clr visible) moves on, so
            // FIND's first look already sees the cleared board.
            ST_INIT_CLR: begin
                if (!clr_r) begin
                    clr_nx = 1'b1;
                end else begin
                    state_nx     = ST_FIND;
                    spawn_cnt_nx = 2'd2;
                end
            end
            ST_READY: begin
                if (!game_over_r && (press_s != 4'd0)) begin
                    state_nx  = ST_ISSUE;
                    mv_dir_nx = pick_dir(press_s);
                end else begin
                    state_nx = ST_READY;
                end
            end
            // new_game cannot cut an offered move; it waits for the handshake.
            ST_ISSUE: begin
                abort_s = 1'b0;
                if (mv_valid_r && bus.mv_ready) begin
                    if (ng_pend_r || new_game) begin
                        abort_s = 1'b1;
                    end else begin
                        state_nx = ST_WAIT_MV;
                    end
                end else begin
                    ng_pend_nx = ng_pend_r | new_game;
                end
            end
            ST_WAIT_MV: begin
                if (bus.mv_done) begin
                    if (bus.mv_changed) begin
                        move_count_nx = move_count_r + 16'd1;
                        spawn_cnt_nx  = 2'd1;
                        state_nx      = ST_FIND;
                    end else begin
                        state_nx = ST_CHECK;
                    end
                end else begin
                    state_nx = ST_WAIT_MV;
                end
            end
            ST_FIND: begin
                if (cell_at(bus.board_in, ptr_r) == 16'd0) begin
                    state_nx     = ST_SPAWN;
                    spawn_idx_nx = ptr_r;
                end else if (scan_cnt_r == 4'd15) begin
                    state_nx = ST_CHECK;
                end else begin
                    ptr_nx      = ptr_r + 4'd1;
                    scan_cnt_nx = scan_cnt_r + 4'd1;
                end
            end
            ST_SPAWN: begin
                spawn_cnt_nx = spawn_cnt_r - 2'd1;
                if (spawn_cnt_r > 2'd1) begin
                    state_nx = ST_FIND;
                end else begin
                    state_nx = ST_CHECK;
                end
            end
            ST_CHECK: begin
                win_nx       = win_r | any_win_s;
                game_over_nx = game_over_r | (board_full_s & ~pair_eq_s);
                state_nx     = ST_READY;
            end
            default: begin
                state_nx = ST_INIT_CLR;
            end
        endcase

        if (abort_s) begin
            state_nx      = ST_INIT_CLR;
            clr_nx        = 1'b0;
            win_nx        = 1'b0;
            game_over_nx  = 1'b0;
            move_count_nx = 16'd0;
            ng_pend_nx    = 1'b0;
        end else begin
            ng_pend_nx = ng_pend_nx;
        end

        // Every entry into FIND starts a fresh scan at the random index.
        if ((state_nx == ST_FIND) && (state_r != ST_FIND)) begin
            ptr_nx      = rnd;
            scan_cnt_nx = 4'd0;
        end else begin
            scan_cnt_nx = scan_cnt_nx;
        end

        // Strobes are tied to exclusive states, so at most one is ever high.
        mv_valid_nx = (state_nx == ST_ISSUE);
        spawn_we_nx = (state_nx == ST_SPAWN);
        busy_nx     = (state_nx != ST_READY);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_INIT_CLR;
            mv_dir_r     <= DIR_U;
            mv_valid_r   <= 1'b0;
            clr_r        <= 1'b0;
            spawn_we_r   <= 1'b0;
            spawn_idx_r  <= 4'd0;
            busy_r       <= 1'b0;
            win_r        <= 1'b0;
            game_over_r  <= 1'b0;
            move_count_r <= 16'd0;
            ptr_r        <= 4'd0;
            scan_cnt_r   <= 4'd0;
            spawn_cnt_r  <= 2'd0;
            ng_pend_r    <= 1'b0;
        end else begin
            state_r      <= state_nx;
            mv_dir_r     <= mv_dir_nx;
            mv_valid_r   <= mv_valid_nx;
            clr_r        <= clr_nx;
            spawn_we_r   <= spawn_we_nx;
            spawn_idx_r  <= spawn_idx_nx;
            busy_r       <= busy_nx;
            win_r        <= win_nx;
            game_over_r  <= game_over_nx;
            move_count_r <= move_count_nx;
            ptr_r        <= ptr_nx;
            scan_cnt_r   <= scan_cnt_nx;
            spawn_cnt_r  <= spawn_cnt_nx;
            ng_pend_r    <= ng_pend_nx;
        end
    end

    assign bus.mv_valid  = mv_valid_r;
    assign bus.mv_dir    = mv_dir_r;
    assign bus.clr       = clr_r;
    assign bus.spawn_we  = spawn_we_r;
    assign bus.spawn_idx = spawn_idx_r;
    assign busy          = busy_r;
    assign win           = win_r;
    assign game_over     = game_over_r;
    assign move_count    = move_count_r;

endmodule

// File: tb/tb_move_sequencer.sv
// -----------------------------------------------------------------------------
// tb_move_sequencer: directed self-checking bench for move_sequencer.
// A small board-engine model applies clr / spawn writes and bench board loads,
// and logs spawns, handshakes and strobe overlaps. A vector table covers
// arbitration and CHECK evaluation; hand sequences cover the multi-cycle cases.
// -----------------------------------------------------------------------------
module tb_move_sequencer;
    import game_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
    logic        new_game = 1'b0;
    logic [3:0]  rnd = 4'd0;
    logic        busy, win, game_over;
    logic [15:0] move_count;

    move_sequencer_if bus();

    move_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_l     (btn_l),
        .btn_r     (btn_r),
        .btn_u     (btn_u),
        .btn_d     (btn_d),
        .new_game  (new_game),
        .rnd       (rnd),
        .bus       (bus),
        .busy      (busy),
        .win       (win),
        .game_over (game_over),
        .move_count(move_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic         load_req = 1'b0;
    logic [255:0] load_val = '0;
    int           clr_cnt = 0, spawn_n = 0, xfer_n = 0, excl_viol = 0;
    logic [3:0]   spawn_log [0:63];

    // Board engine model and event logger.
    always @(posedge clk) begin
        if (bus.clr) begin
            bus.board_in <= '0;
        end else if (bus.spawn_we) begin
            bus.board_in[int'(bus.spawn_idx) * 16 +: 16] <= 16'd1;
        end else if (load_req) begin
            bus.board_in <= load_val;
        end
        if (bus.clr) clr_cnt <= clr_cnt + 1;
        if (bus.spawn_we) begin
            spawn_log[spawn_n[5:0]] <= bus.spawn_idx;
            spawn_n <= spawn_n + 1;
        end
        if (bus.mv_valid && bus.mv_ready) xfer_n <= xfer_n + 1;
        if ((int'(bus.mv_valid) + int'(bus.clr) + int'(bus.spawn_we)) > 1) excl_viol <= excl_viol + 1;
    end

    typedef struct {
        logic [3:0] btns;     // {u, d, l, r}
        int         kind;     // board pattern for mk_board()
        logic [1:0] exp_dir;
        logic       exp_win;
        logic       exp_go;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk({name, " idle"}, 64'(busy), 64'd0);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!bus.mv_valid && n < 12) begin
            tick();
            n++;
        end
        chk({name, " valid"}, 64'(bus.mv_valid), 64'd1);
    endtask

    task automatic load_board(input logic [255:0] b);
        load_val = b;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic start_game(input string name);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        tick();
        tick();
        wait_idle(name);
    endtask

    // Press, optional stall with ready low, handshake, mv_done, back to idle.
    task automatic run_move(input string name, input logic [3:0] btns, input logic [1:0] exp_dir,
                            input int stall, input logic changed);
        {btn_u, btn_d, btn_l, btn_r} = btns;
        wait_valid(name);
        chk({name, " dir"}, 64'(bus.mv_dir), 64'(exp_dir));
        {btn_u, btn_d, btn_l, btn_r} = 4'b0000;
        for (int i = 0; i < stall; i++) begin
            chk($sformatf("%s stall%0d", name, i), 64'({bus.mv_valid, bus.mv_dir}), 64'({1'b1, exp_dir}));
            tick();
        end
        bus.mv_ready = 1'b1;
        tick();
        bus.mv_ready = 1'b0;
        chk({name, " valid drop"}, 64'(bus.mv_valid), 64'd0);
        tick();
        bus.mv_done    = 1'b1;
        bus.mv_changed = changed;
        tick();
        bus.mv_done    = 1'b0;
        bus.mv_changed = 1'b0;
        tick();
        wait_idle(name);
    endtask

    function automatic logic [255:0] mk_board(input int kind);
        logic [255:0] b;
        b = '0;
        for (int i = 0; i < 16; i++) begin
            case (kind)
                0:       b[i*16 +: 16] = (i == 0) ? 16'd1 : 16'd0;
                1:       b[i*16 +: 16] = (i == 7) ? 16'd11 : 16'd0;
                2:       b[i*16 +: 16] = (i == 3) ? 16'd10 : 16'd0;
                3:       b[i*16 +: 16] = (((i / 4) + (i % 4)) % 2 == 0) ? 16'd1 : 16'd2;
                4:       b[i*16 +: 16] = 16'(i + 1);
                5:       b[i*16 +: 16] = 16'd2;
                6:       b[i*16 +: 16] = (i == 4) ? 16'd0 : 16'd3;
                default: b[i*16 +: 16] = 16'd0;
            endcase
        end
        return b;
    endfunction

    initial begin
        int   x0, s0, c0;
        logic seen;

        vecs[0] = '{4'b1010, 0, 2'd0, 1'b0, 1'b0};  // U+L together: U wins
        vecs[1] = '{4'b0111, 1, 2'd1, 1'b1, 1'b0};  // D+L+R, tile 11 -> win
        vecs[2] = '{4'b0011, 2, 2'd2, 1'b0, 1'b0};  // L+R, tile 10 only
        vecs[3] = '{4'b0001, 3, 2'd3, 1'b0, 1'b1};  // checkerboard -> game over
        vecs[4] = '{4'b1000, 4, 2'd0, 1'b1, 1'b1};  // 1..16: win and game over
        vecs[5] = '{4'b0100, 5, 2'd1, 1'b0, 1'b0};  // full but mergeable

        bus.mv_ready   = 1'b0;
        bus.mv_done    = 1'b0;
        bus.mv_changed = 1'b0;
        rnd            = 4'd5;

        // Reset values.
        tick();
        tick();
        chk("reset outputs",
            64'({bus.mv_valid, bus.clr, bus.spawn_we, busy, win, game_over, bus.mv_dir, bus.spawn_idx, move_count}),
            64'd0);
        rst_n = 1'b1;

        // Power-up: clear, spawn at 5, then next free cell from rnd=5 is 6.
        tick();
        tick();
        wait_idle("init");
        chk("init clr count", 64'(clr_cnt), 64'd1);
        chk("init spawn count", 64'(spawn_n), 64'd2);
        chk("init spawn0 idx", 64'(spawn_log[0]), 64'd5);
        chk("init spawn1 idx", 64'(spawn_log[1]), 64'd6);
        chk("init move_count", 64'(move_count), 64'd0);

        // Table: arbitration and CHECK evaluation with unchanged moves.
        for (int v = 0; v < 6; v++) begin
            start_game($sformatf("v%0d ng", v));
            load_board(mk_board(vecs[v].kind));
            x0 = xfer_n;
            s0 = spawn_n;
            run_move($sformatf("v%0d", v), vecs[v].btns, vecs[v].exp_dir, 0, 1'b0);
            repeat (4) tick();
            chk($sformatf("v%0d xfers", v), 64'(xfer_n - x0), 64'd1);
            chk($sformatf("v%0d spawns", v), 64'(spawn_n - s0), 64'd0);
            chk($sformatf("v%0d win", v), 64'(win), 64'(vecs[v].exp_win));
            chk($sformatf("v%0d game_over", v), 64'(game_over), 64'(vecs[v].exp_go));
            chk($sformatf("v%0d move_count", v), 64'(move_count), 64'd0);
        end

        // Stalled handshake, then changed move with only cell 4 empty, rnd=9.
        start_game("stall ng");
        load_board(mk_board(6));
        rnd = 4'd9;
        x0 = xfer_n;
        s0 = spawn_n;
        run_move("stall", 4'b0010, 2'd2, 7, 1'b1);
        chk("stall xfers", 64'(xfer_n - x0), 64'd1);
        chk("wrap spawns", 64'(spawn_n - s0), 64'd1);
        chk("wrap spawn idx", 64'(spawn_log[s0[5:0]]), 64'd4);
        chk("wrap move_count", 64'(move_count), 64'd1);
        chk("wrap game_over", 64'(game_over), 64'd0);

        // Full unmergeable board after a changed move: no spawn, game over.
        load_board(mk_board(3));
        s0 = spawn_n;
        run_move("full", 4'b0100, 2'd1, 0, 1'b1);
        chk("full spawns", 64'(spawn_n - s0), 64'd0);
        chk("full game_over", 64'(game_over), 64'd1);
        chk("full move_count", 64'(move_count), 64'd2);
        x0 = xfer_n;
        seen = 1'b0;
        btn_u = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | bus.mv_valid;
        end
        btn_u = 1'b0;
        chk("over press ignored", 64'(seen), 64'd0);
        chk("over no xfer", 64'(xfer_n - x0), 64'd0);
        start_game("over ng");
        chk("ng game_over", 64'(game_over), 64'd0);
        chk("ng move_count", 64'(move_count), 64'd0);

        // new_game during ISSUE is deferred; the late mv_done is ignored.
        x0 = xfer_n;
        s0 = spawn_n;
        c0 = clr_cnt;
        btn_r = 1'b1;
        wait_valid("pend");
        btn_r = 1'b0;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        tick();
        chk("pend valid held", 64'(bus.mv_valid), 64'd1);
        bus.mv_ready = 1'b1;
        tick();
        bus.mv_ready = 1'b0;
        bus.mv_done = 1'b1;
        bus.mv_changed = 1'b1;
        tick();
        bus.mv_done = 1'b0;
        bus.mv_changed = 1'b0;
        tick();
        wait_idle("pend");
        chk("pend xfers", 64'(xfer_n - x0), 64'd1);
        chk("pend clr", 64'(clr_cnt - c0), 64'd1);
        chk("pend spawns", 64'(spawn_n - s0), 64'd2);
        chk("pend move_count", 64'(move_count), 64'd0);

        chk("strobe exclusivity", 64'(excl_viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
